// File: rtl/lmg_pkg.sv
// Shared types for the legal move generator: piece codes, colours, board
// coordinates, square index and move record, plus the move-drain FSM states.
package lmg_pkg;

    typedef enum logic [2:0] {
        EMPTY   = 3'o0,
        PAWN    = 3'o1,
        KNIGHT  = 3'o2,
        BISHOP  = 3'o3,
        ROOK    = 3'o4,
        QUEEN   = 3'o5,
        KING    = 3'o6,
        NOTUSED = 3'o7
    } piece_e;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    localparam logic [2:0] COLA = 3'd0, COLB = 3'd1, COLC = 3'd2, COLD = 3'd3;
    localparam logic [2:0] COLE = 3'd4, COLF = 3'd5, COLG = 3'd6, COLH = 3'd7;
    localparam logic [2:0] ROW1 = 3'd0, ROW2 = 3'd1, ROW3 = 3'd2, ROW4 = 3'd3;
    localparam logic [2:0] ROW5 = 3'd4, ROW6 = 3'd5, ROW7 = 3'd6, ROW8 = 3'd7;

    // Square index is {col, row}: a1=0, a8=7, b1=8.
    typedef logic [5:0] sq_t;

    typedef struct packed {
        sq_t    from;
        sq_t    to;
        piece_e piece;
        piece_e promo;
    } move_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_DONE
    } drain_state_e;

    function automatic sq_t mk_sq(input logic [2:0] col, input logic [2:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/lmg_move_drain_if.sv
// Cell-array read port and move-record stream of the move drain.
// master = drain side, slave = cell array / move consumer side.
interface lmg_move_drain_if;
    import lmg_pkg::*;

    logic        sq_rd;
    sq_t         sq_addr;
    logic        sq_color;
    piece_e      sq_piece;
    logic [63:0] sq_targets;

    logic        move_valid;
    logic        move_ready;
    sq_t         move_from;
    sq_t         move_to;
    piece_e      move_piece;
    piece_e      move_promo;

    modport master (
        output sq_rd, sq_addr,
        input  sq_color, sq_piece, sq_targets,
        output move_valid, move_from, move_to, move_piece, move_promo,
        input  move_ready
    );

    modport slave (
        input  sq_rd, sq_addr,
        output sq_color, sq_piece, sq_targets,
        input  move_valid, move_from, move_to, move_piece, move_promo,
        output move_ready
    );

endinterface

// File: rtl/lsb_pick64.sv
// Combinational lowest-set-bit encoder over a 64-bit mask.
module lsb_pick64 (
    input  logic [63:0] mask_i,
    output logic [5:0]  idx_o,
    output logic        any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 63; i >= 0; i--) begin
            if (mask_i[i]) idx_o = 6'(i);
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/lmg_move_drain.sv
// Scans all 64 squares of the cell array and serializes the legal-target masks
// of the side to move into a valid/ready move stream with a saturating count.
// Optional macro LMG_PROMO_EXPAND_EN: emit Q,R,B,N for every promotion target.
module lmg_move_drain
    import lmg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             side,
    lmg_move_drain_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] move_count
);

    drain_state_e     state_q, state_d;
    sq_t              idx_q;
    logic             side_q;
    piece_e           piece_q;
    logic [63:0]      mask_q;
    logic [CNT_W-1:0] cnt_q;

    sq_t         to_idx;
    logic        mask_any;
    logic        promo_sq;
    piece_e      promo_code;
    logic        bit_done;
    logic        hs;
    logic [63:0] mask_clr;
    logic        emit_last;
    logic        load_skip;
    logic        last_sq;

    lsb_pick64 u_pick (
        .mask_i (mask_q),
        .idx_o  (to_idx),
        .any_o  (mask_any)
    );

    assign promo_sq  = (piece_q == PAWN) &&
                       (to_idx[2:0] == ((side_q == WHITE) ? ROW8 : ROW1));
    assign hs        = bus.move_valid && bus.move_ready;
    assign mask_clr  = mask_q & ~(64'd1 << to_idx);
    assign emit_last = hs && bit_done && (mask_clr == '0);
    assign load_skip = (bus.sq_piece == EMPTY) || (bus.sq_color != side_q) ||
                       (bus.sq_targets == '0);
    assign last_sq   = (idx_q == 6'd63);

`ifdef LMG_PROMO_EXPAND_EN
    logic [1:0] sub_q;

    always_comb begin
        case (sub_q)
            2'd0:    promo_code = QUEEN;
            2'd1:    promo_code = ROOK;
            2'd2:    promo_code = BISHOP;
            default: promo_code = KNIGHT;
        endcase
    end

    // The target bit stays in the mask until the knight under-promotion is taken.
    assign bit_done = !promo_sq || (sub_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_q <= 2'd0;
        end else if (hs) begin
            sub_q <= (promo_sq && !bit_done) ? sub_q + 2'd1 : 2'd0;
        end
    end
`else
    assign promo_code = QUEEN;
    assign bit_done   = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = load_skip ? (last_sq ? S_DONE : S_FETCH) : S_EMIT;
            S_EMIT:  if (emit_last) state_d = last_sq ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.sq_rd      = (state_q == S_FETCH);
        bus.sq_addr    = idx_q;
        bus.move_valid = (state_q == S_EMIT) && mask_any;
        bus.move_from  = idx_q;
        bus.move_to    = to_idx;
        bus.move_piece = piece_q;
        bus.move_promo = promo_sq ? promo_code : EMPTY;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            side_q  <= WHITE;
            piece_q <= EMPTY;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    idx_q  <= '0;
                    cnt_q  <= '0;
                    side_q <= side;
                end
                S_LOAD: begin
                    piece_q <= bus.sq_piece;
                    mask_q  <= bus.sq_targets;
                    if (load_skip) idx_q <= idx_q + 6'd1;
                end
                S_EMIT: if (hs) begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                    if (bit_done) mask_q <= mask_clr;
                    if (emit_last) idx_q <= idx_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign move_count = cnt_q;

endmodule
